// File: rtl/mem_access_ctrl_pkg.sv
//==============================================================================
// Module : mem_pkg
// Shared types and constants for the data-memory access controller.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } mac_state_e;

    typedef enum logic [1:0] {
        LR_NONE  = 2'd0,
        LR_LEFT  = 2'd1,
        LR_RIGHT = 2'd2
    } lr_e;

    // Access sizes as carried by mem_rsize, in bytes
    localparam logic [2:0] SZ_B = 3'd1;
    localparam logic [2:0] SZ_H = 3'd2;
    localparam logic [2:0] SZ_W = 3'd4;

endpackage

`default_nettype wire

// File: rtl/mem_access_ctrl_load_align.sv
//==============================================================================
// Module : load_align
// Lane-selects, extends and LWL/LWR-merges raw bus read data into a load result.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  k,
    input  logic [2:0]  rsize,
    input  logic        sign_ext,
    input  lr_e         lr,
    input  logic [31:0] rt,
    output logic [31:0] ld_data
);

    logic [31:0] w_shr;

    always_comb begin
        w_shr   = rdata >> {k, 3'b000};
        ld_data = rdata;
        case (lr)
            // ~k equals 3-k for a two-bit lane index
            LR_LEFT:  ld_data = (rdata << {~k, 3'b000}) | (rt & ~(32'hFFFF_FFFF << {~k, 3'b000}));
            LR_RIGHT: ld_data = w_shr | (rt & ~(32'hFFFF_FFFF >> {k, 3'b000}));
            default: begin
                case (rsize)
                    SZ_B:    ld_data = {{24{sign_ext & w_shr[7]}}, w_shr[7:0]};
                    SZ_H:    ld_data = {{16{sign_ext & w_shr[15]}}, w_shr[15:0]};
                    default: ld_data = rdata;
                endcase
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
//==============================================================================
// Module : mem_access_ctrl
// Single-port data-memory sequencer: request latch, bus FSM, store lanes, load return.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic              mem_wr,
    input  logic [2:0]        mem_rsize,
    input  logic              mem_signExt,
    input  logic [1:0]        mem_left_right,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rtReg,
    input  logic              mem_cached,
    input  logic [4:0]        mem_wRegAddr,
    output logic              stall_req,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [3:0]        data_wstrb,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    output logic              data_cached,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic              ld_valid,
    output logic [4:0]        ld_wRegAddr,
    output logic [DATA_W-1:0] ld_data
);

    mac_state_e        r_state;
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_rt;
    logic [2:0]        r_rsize;
    lr_e               r_lr;
    logic              r_sext;
    logic              r_wr;
    logic              r_cached;
    logic [4:0]        r_waddr;
    logic              r_ld_valid;
    logic [4:0]        r_ld_waddr;
    logic [DATA_W-1:0] r_ld_data;

    logic [DATA_W-1:0] w_ld_data;
    logic [1:0]        w_k;
    logic              w_done;

    assign w_k = r_addr[1:0];

    load_align u_load_align (
        .rdata    (data_rdata),
        .k        (w_k),
        .rsize    (r_rsize),
        .sign_ext (r_sext),
        .lr       (r_lr),
        .rt       (r_rt),
        .ld_data  (w_ld_data)
    );

    // The beat completes either in DATA or when accept and data coincide in ADDR
    assign w_done    = (r_state == DATA && data_data_ok) ||
                       (r_state == ADDR && data_addr_ok && data_data_ok);
    assign stall_req = (mem_valid && !w_done) || (r_state == DRAIN);

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_addr     <= '0;
            r_rt       <= '0;
            r_rsize    <= '0;
            r_lr       <= LR_NONE;
            r_sext     <= 1'b0;
            r_wr       <= 1'b0;
            r_cached   <= 1'b0;
            r_waddr    <= '0;
            r_ld_valid <= 1'b0;
            r_ld_waddr <= '0;
            r_ld_data  <= '0;
        end else begin
            r_ld_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (mem_valid && !flush) begin
                        r_addr   <= mem_addr;
                        r_rt     <= mem_rtReg;
                        r_rsize  <= mem_rsize;
                        r_lr     <= lr_e'(mem_left_right);
                        r_sext   <= mem_signExt;
                        r_wr     <= mem_wr;
                        r_cached <= mem_cached;
                        r_waddr  <= mem_wRegAddr;
                        r_req    <= 1'b1;
                        r_state  <= ADDR;
                    end
                end
                ADDR: begin
                    if (data_addr_ok && data_data_ok) begin
                        r_req   <= 1'b0;
                        r_state <= IDLE;
                        if (!r_wr && !flush) begin
                            r_ld_valid <= 1'b1;
                            r_ld_waddr <= r_waddr;
                            r_ld_data  <= w_ld_data;
                        end
                    end else if (data_addr_ok) begin
                        r_req   <= 1'b0;
                        r_state <= flush ? DRAIN : DATA;
                    end else if (flush) begin
                        r_req   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                DATA: begin
                    // A flush coinciding with data_ok has nothing left to drain
                    if (data_data_ok) begin
                        r_state <= IDLE;
                        if (!r_wr && !flush) begin
                            r_ld_valid <= 1'b1;
                            r_ld_waddr <= r_waddr;
                            r_ld_data  <= w_ld_data;
                        end
                    end else if (flush) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (data_data_ok) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        data_wstrb = 4'b0000;
        data_wdata = r_rt;
        data_size  = 2'd0;
        case (r_lr)
            LR_LEFT: begin
                data_wstrb = 4'hF >> ~w_k;
                data_wdata = r_rt >> {~w_k, 3'b000};
                data_size  = 2'd2;
            end
            LR_RIGHT: begin
                data_wstrb = 4'hF << w_k;
                data_wdata = r_rt << {w_k, 3'b000};
                data_size  = 2'd2;
            end
            default: begin
                case (r_rsize)
                    SZ_B: begin
                        data_wstrb = 4'b0001 << w_k;
                        data_wdata = {4{r_rt[7:0]}};
                        data_size  = 2'd0;
                    end
                    SZ_H: begin
                        data_wstrb = 4'b0011 << w_k;
                        data_wdata = {2{r_rt[15:0]}};
                        data_size  = 2'd1;
                    end
                    SZ_W: begin
                        data_wstrb = 4'hF;
                        data_size  = 2'd2;
                    end
                    default: data_wstrb = 4'b0000;
                endcase
            end
        endcase
        if (!r_wr) begin
            data_wstrb = 4'b0000;
        end
    end

    assign data_addr   = (r_lr == LR_NONE) ? r_addr : {r_addr[ADDR_W-1:2], 2'b00};
    assign data_req    = r_req;
    assign data_wr     = r_wr;
    assign data_cached = r_cached;
    assign ld_valid    = r_ld_valid;
    assign ld_wRegAddr = r_ld_waddr;
    assign ld_data     = r_ld_data;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
//==============================================================================
// Module : tb_mem_access_ctrl
// Directed bench for mem_access_ctrl with a load-result scoreboard.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        flush;
    logic        mem_valid;
    logic        mem_wr;
    logic [2:0]  mem_rsize;
    logic        mem_signExt;
    logic [1:0]  mem_left_right;
    logic [31:0] mem_addr;
    logic [31:0] mem_rtReg;
    logic        mem_cached;
    logic [4:0]  mem_wRegAddr;
    logic        stall_req;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_cached;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        ld_valid;
    logic [4:0]  ld_wRegAddr;
    logic [31:0] ld_data;

    int vectors     = 0;
    int miscompares = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .flush          (flush),
        .mem_valid      (mem_valid),
        .mem_wr         (mem_wr),
        .mem_rsize      (mem_rsize),
        .mem_signExt    (mem_signExt),
        .mem_left_right (mem_left_right),
        .mem_addr       (mem_addr),
        .mem_rtReg      (mem_rtReg),
        .mem_cached     (mem_cached),
        .mem_wRegAddr   (mem_wRegAddr),
        .stall_req      (stall_req),
        .data_req       (data_req),
        .data_wr        (data_wr),
        .data_size      (data_size),
        .data_wstrb     (data_wstrb),
        .data_addr      (data_addr),
        .data_wdata     (data_wdata),
        .data_cached    (data_cached),
        .data_addr_ok   (data_addr_ok),
        .data_data_ok   (data_data_ok),
        .data_rdata     (data_rdata),
        .ld_valid       (ld_valid),
        .ld_wRegAddr    (ld_wRegAddr),
        .ld_data        (ld_data)
    );

    task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every ld_valid pulse must match the oldest expected load
    always @(negedge clk) begin
        if (ld_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ld_valid", 37'd1, 37'd0);
            end else begin
                check("ld_result", {ld_wRegAddr, ld_data}, exp_q.pop_front());
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic [31:0] rt, input logic [2:0] size,
                             input logic sext, input logic [1:0] lr, input logic wr, input logic [4:0] wreg);
        mem_valid      = 1'b1;
        mem_addr       = addr;
        mem_rtReg      = rt;
        mem_rsize      = size;
        mem_signExt    = sext;
        mem_left_right = lr;
        mem_wr         = wr;
        mem_wRegAddr   = wreg;
        mem_cached     = 1'b1;
    endtask

    // Minimum-latency access: request at cycle 0, accept+data at cycle 1
    task automatic single(input string tag, input logic [31:0] addr, input logic [31:0] rt,
                          input logic [2:0] size, input logic sext, input logic [1:0] lr,
                          input logic wr, input logic [31:0] rdata, input logic [31:0] exp_ld,
                          input logic [31:0] exp_addr, input logic [1:0] exp_size,
                          input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata);
        next_cycle();
        drive_req(addr, rt, size, sext, lr, wr, 5'd7);
        if (!wr) exp_q.push_back({5'd7, exp_ld});
        @(negedge clk);
        check({tag, "_stall_c0"}, {36'd0, stall_req}, 37'd1);
        check({tag, "_req_c0"}, {36'd0, data_req}, 37'd0);
        next_cycle();
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = rdata;
        @(negedge clk);
        check({tag, "_req_c1"}, {36'd0, data_req}, 37'd1);
        check({tag, "_stall_c1"}, {36'd0, stall_req}, 37'd0);
        check({tag, "_addr"}, {5'd0, data_addr}, {5'd0, exp_addr});
        check({tag, "_size"}, {35'd0, data_size}, {35'd0, exp_size});
        check({tag, "_wr"}, {36'd0, data_wr}, {36'd0, wr});
        if (wr) begin
            check({tag, "_wstrb"}, {33'd0, data_wstrb}, {33'd0, exp_wstrb});
            check({tag, "_wdata"}, {5'd0, data_wdata}, {5'd0, exp_wdata});
        end
        next_cycle();
        mem_valid    = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        @(negedge clk);
        check({tag, "_ld_valid_c2"}, {36'd0, ld_valid}, {36'd0, ~wr});
        check({tag, "_req_c2"}, {36'd0, data_req}, 37'd0);
    endtask

    initial begin
        aresetn = 1'b0; flush = 1'b0; mem_valid = 1'b0; mem_wr = 1'b0; mem_rsize = 3'd4;
        mem_signExt = 1'b0; mem_left_right = 2'b00; mem_addr = '0; mem_rtReg = '0;
        mem_cached = 1'b0; mem_wRegAddr = '0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        data_rdata = '0;

        repeat (3) next_cycle();
        @(negedge clk);
        check("rst_req", {36'd0, data_req}, 37'd0);
        check("rst_stall", {36'd0, stall_req}, 37'd0);
        check("rst_ld_valid", {36'd0, ld_valid}, 37'd0);
        check("rst_addr", {5'd0, data_addr}, 37'd0);
        check("rst_wstrb", {33'd0, data_wstrb}, 37'd0);
        next_cycle();
        aresetn = 1'b1;

        // Loads
        single("lw",  32'h100, 32'h0, 3'd4, 1'b0, 2'b00, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h100, 2'd2, 4'h0, 32'h0);
        single("lb",  32'h103, 32'h0, 3'd1, 1'b1, 2'b00, 1'b0, 32'h80112233, 32'hFFFFFF80, 32'h103, 2'd0, 4'h0, 32'h0);
        single("lbu", 32'h103, 32'h0, 3'd1, 1'b0, 2'b00, 1'b0, 32'h80112233, 32'h00000080, 32'h103, 2'd0, 4'h0, 32'h0);
        single("lh",  32'h102, 32'h0, 3'd2, 1'b1, 2'b00, 1'b0, 32'h80012233, 32'hFFFF8001, 32'h102, 2'd1, 4'h0, 32'h0);
        single("lhu", 32'h100, 32'h0, 3'd2, 1'b0, 2'b00, 1'b0, 32'h80019233, 32'h00009233, 32'h100, 2'd1, 4'h0, 32'h0);
        single("lwl", 32'h201, 32'h11223344, 3'd4, 1'b0, 2'b01, 1'b0, 32'hAABBCCDD, 32'hCCDD3344, 32'h200, 2'd2, 4'h0, 32'h0);
        single("lwr", 32'h201, 32'h11223344, 3'd4, 1'b0, 2'b10, 1'b0, 32'hAABBCCDD, 32'h11AABBCC, 32'h200, 2'd2, 4'h0, 32'h0);

        // Stores
        single("swr", 32'h302, 32'h11223344, 3'd4, 1'b0, 2'b10, 1'b1, 32'h0, 32'h0, 32'h300, 2'd2, 4'b1100, 32'h33440000);
        single("swl", 32'h301, 32'h11223344, 3'd4, 1'b0, 2'b01, 1'b1, 32'h0, 32'h0, 32'h300, 2'd2, 4'b0011, 32'h00001122);
        single("sb",  32'h101, 32'h000000A5, 3'd1, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0, 32'h101, 2'd0, 4'b0010, 32'hA5A5A5A5);
        single("sh",  32'h102, 32'h0000BEEF, 3'd2, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0, 32'h102, 2'd1, 4'b1100, 32'hBEEFBEEF);
        single("sw",  32'h104, 32'h12345678, 3'd4, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0, 32'h104, 2'd2, 4'hF, 32'h12345678);

        // Flush in IDLE: request ignored
        next_cycle();
        drive_req(32'h400, 32'h0, 3'd4, 1'b0, 2'b00, 1'b0, 5'd3);
        flush = 1'b1;
        next_cycle();
        mem_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_idle_req", {36'd0, data_req}, 37'd0);

        // Flush in ADDR without addr_ok: back to IDLE, req drops
        next_cycle();
        drive_req(32'h400, 32'h0, 3'd4, 1'b0, 2'b00, 1'b0, 5'd3);
        next_cycle();
        mem_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("flush_addr_req_c1", {36'd0, data_req}, 37'd1);
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        check("flush_addr_req_c2", {36'd0, data_req}, 37'd0);
        check("flush_addr_stall_c2", {36'd0, stall_req}, 37'd0);

        // Flush in DATA: drain the outstanding beat, no ld_valid
        next_cycle();
        drive_req(32'h100, 32'h0, 3'd4, 1'b0, 2'b00, 1'b0, 5'd4);
        next_cycle();
        data_addr_ok = 1'b1;
        next_cycle();
        data_addr_ok = 1'b0; mem_valid = 1'b0; flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        check("drain_stall_c3", {36'd0, stall_req}, 37'd1);
        check("drain_req_c3", {36'd0, data_req}, 37'd0);
        next_cycle();
        data_data_ok = 1'b1; data_rdata = 32'h5555AAAA;
        @(negedge clk);
        check("drain_stall_c4", {36'd0, stall_req}, 37'd1);
        next_cycle();
        data_data_ok = 1'b0;
        @(negedge clk);
        check("drain_idle_stall_c5", {36'd0, stall_req}, 37'd0);
        check("drain_no_ld_c5", {36'd0, ld_valid}, 37'd0);
        single("post_drain", 32'h108, 32'h0, 3'd4, 1'b0, 2'b00, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 32'h108, 2'd2, 4'h0, 32'h0);

        // Reset while in DATA
        next_cycle();
        drive_req(32'h100, 32'h0, 3'd4, 1'b0, 2'b00, 1'b0, 5'd5);
        next_cycle();
        data_addr_ok = 1'b1;
        next_cycle();
        data_addr_ok = 1'b0; mem_valid = 1'b0; aresetn = 1'b0;
        next_cycle();
        aresetn = 1'b1;
        @(negedge clk);
        check("rst_data_req", {36'd0, data_req}, 37'd0);
        check("rst_data_stall", {36'd0, stall_req}, 37'd0);
        check("rst_data_ld_valid", {36'd0, ld_valid}, 37'd0);
        single("post_reset", 32'h10C, 32'h0, 3'd4, 1'b0, 2'b00, 1'b0, 32'h01234567, 32'h01234567, 32'h10C, 2'd2, 4'h0, 32'h0);

        repeat (3) next_cycle();
        check("scoreboard_empty", 37'(exp_q.size()), 37'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
